// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl
//   Sequencer for an in-place radix-2 DIT FFT. It issues one butterfly per
//   cycle for each of LOG2N stages and generates read addresses A/B and a
//   twiddle ROM address. Matching write-back addresses come out PIPE_LAT
//   cycles later. The pipeline is drained between stages so that a stage
//   never reads a location that is still in flight from the previous stage.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   start                 one-cycle run request, honoured only in IDLE
//   busy                  high while in RUN or DRAIN
//   done                  one-cycle pulse in FIN, after the final write-back
//   stage                 current stage index s (0 in IDLE)
//   rd_en                 issue strobe to memory and butterfly
//   rd_addr_a, rd_addr_b  butterfly input addresses
//   tw_addr               twiddle ROM address, aligned with rd_en
//   wr_en                 write strobe, rd_en delayed by PIPE_LAT cycles
//   wr_addr_a, wr_addr_b  write addresses, rd_addr_* delayed by PIPE_LAT
//
// Handshake: there is no back-pressure. rd_en and wr_en are single-cycle
// strobes and the memory must accept every one of them. start is a request
// that is dropped, not queued, whenever the FSM is not in IDLE.
module fft_stage_ctrl #(
  parameter int LOG2N   = 3,
  parameter int RD_LAT  = 1,
  parameter int BF_LAT  = 4,
  parameter int STAGE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [STAGE_W-1:0] stage,
  output logic               rd_en,
  output logic [LOG2N-1:0]   rd_addr_a,
  output logic [LOG2N-1:0]   rd_addr_b,
  output logic [LOG2N-2:0]   tw_addr,
  output logic               wr_en,
  output logic [LOG2N-1:0]   wr_addr_a,
  output logic [LOG2N-1:0]   wr_addr_b
);

  localparam int HALF     = (1 << LOG2N) / 2;
  localparam int PIPE_LAT = RD_LAT + BF_LAT;
  localparam int KW       = LOG2N - 1;
  localparam int DW       = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t              state;
  logic [KW-1:0]       k;
  logic [DW-1:0]       dcnt;

  // Stage/index of the butterfly that would be issued on the next edge.
  logic [STAGE_W-1:0]  iss_s;
  logic [KW-1:0]       iss_k;
  logic [LOG2N-1:0]    iss_a;
  logic [LOG2N-1:0]    iss_b;
  logic [LOG2N-2:0]    iss_tw;
  int                  sh;
  int                  span_i;
  int                  pos_i;
  int                  grp_i;
  int                  a_i;

  // Write-back delay line: entry 0 is loaded from the registered read
  // outputs, so the last entry is exactly PIPE_LAT cycles behind them.
  logic                dl_v [PIPE_LAT];
  logic [LOG2N-1:0]    dl_a [PIPE_LAT];
  logic [LOG2N-1:0]    dl_b [PIPE_LAT];

  always_comb begin
    iss_s = '0;
    iss_k = '0;
    case (state)
      RUN:   begin iss_s = stage;        iss_k = k + 1'b1; end
      DRAIN: begin iss_s = stage + 1'b1; iss_k = '0;       end
      default: ;
    endcase
    // Butterflies are grouped in blocks of span; a and b sit span apart.
    sh     = int'(iss_s);
    span_i = 1 << sh;
    pos_i  = int'(iss_k) & (span_i - 1);
    grp_i  = int'(iss_k) >> sh;
    a_i    = (grp_i << (sh + 1)) | pos_i;
    iss_a  = LOG2N'(a_i);
    iss_b  = LOG2N'(a_i + span_i);
    iss_tw = (LOG2N-1)'(pos_i << (LOG2N - 1 - sh));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      dcnt      <= '0;
      stage     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      // Strobes and addresses default to zero; a branch that issues a
      // butterfly overrides them for exactly that cycle.
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      case (state)
        IDLE: begin
          stage <= '0;
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            k         <= '0;
            rd_en     <= 1'b1;
            rd_addr_a <= iss_a;
            rd_addr_b <= iss_b;
            tw_addr   <= iss_tw;
          end
        end
        RUN: begin
          if (int'(k) == HALF - 1) begin
            state <= DRAIN;
            dcnt  <= '0;
          end else begin
            k         <= iss_k;
            rd_en     <= 1'b1;
            rd_addr_a <= iss_a;
            rd_addr_b <= iss_b;
            tw_addr   <= iss_tw;
          end
        end
        DRAIN: begin
          if (int'(dcnt) == PIPE_LAT - 1) begin
            if (int'(stage) < LOG2N - 1) begin
              state     <= RUN;
              stage     <= iss_s;
              k         <= '0;
              rd_en     <= 1'b1;
              rd_addr_a <= iss_a;
              rd_addr_b <= iss_b;
              tw_addr   <= iss_tw;
            end else begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
              stage <= '0;
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        dl_v[i] <= 1'b0;
        dl_a[i] <= '0;
        dl_b[i] <= '0;
      end
    end else begin
      dl_v[0] <= rd_en;
      dl_a[0] <= rd_addr_a;
      dl_b[0] <= rd_addr_b;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_a[i] <= dl_a[i-1];
        dl_b[i] <= dl_b[i-1];
      end
    end
  end

  assign wr_en     = dl_v[PIPE_LAT-1];
  assign wr_addr_a = dl_a[PIPE_LAT-1];
  assign wr_addr_b = dl_b[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Testbench for fft_stage_ctrl: two instances (N=8 defaults, and N=16 with
// RD_LAT=2) driven by directed then random start/rst pulses. Expected outputs
// come from the run schedule: a run accepted at cycle c0 has offset
// off = t-c0-1; stage = off/(N/2+PIPE_LAT), reads in the first N/2 cycles of
// each stage, writes PIPE_LAT cycles after reads, done at off = LOG2N*period.
module tb_fft_stage_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, start1;

  logic       busy0, done0, rd_en0, wr_en0;
  logic [3:0] stage0;
  logic [2:0] rd_a0, rd_b0, wr_a0, wr_b0;
  logic [1:0] tw0;

  logic       busy1, done1, rd_en1, wr_en1;
  logic [3:0] stage1;
  logic [3:0] rd_a1, rd_b1, wr_a1, wr_b1;
  logic [2:0] tw1;

  fft_stage_ctrl #(.LOG2N(3), .RD_LAT(1), .BF_LAT(4), .STAGE_W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .stage(stage0), .rd_en(rd_en0), .rd_addr_a(rd_a0), .rd_addr_b(rd_b0),
    .tw_addr(tw0), .wr_en(wr_en0), .wr_addr_a(wr_a0), .wr_addr_b(wr_b0)
  );

  fft_stage_ctrl #(.LOG2N(4), .RD_LAT(2), .BF_LAT(4), .STAGE_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .stage(stage1), .rd_en(rd_en1), .rd_addr_a(rd_a1), .rd_addr_b(rd_b1),
    .tw_addr(tw1), .wr_en(wr_en1), .wr_addr_a(wr_a1), .wr_addr_b(wr_b1)
  );

  int errors = 0;
  int checks = 0;
  int t = 0;
  int c0_0 = -1;   // accept cycle of the current run, -1 when none
  int c0_1 = -1;
  int wr_cnt0 = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, t, got, exp);
    end
  endtask

  // Butterfly addressing straight from the DIT definition.
  task automatic addr_of(input int l, input int s, input int k,
                         output int a, output int b, output int tw);
    int span, pos, grp;
    span = 2 ** s;
    pos  = k % span;
    grp  = k / span;
    a    = grp * 2 * span + pos;
    b    = a + span;
    tw   = pos * (2 ** (l - 1 - s));
  endtask

  function automatic bit is_idle(input int l, input int p, input int c0, input int tt);
    int per;
    per = (2 ** l) / 2 + p;
    return (c0 < 0) || (tt - c0 - 1 > l * per);
  endfunction

  task automatic model_check(input string nm, input int l, input int p, input int c0,
                             input int o_busy, input int o_done, input int o_stage,
                             input int o_rd, input int o_ra, input int o_rb, input int o_tw,
                             input int o_wr, input int o_wa, input int o_wb);
    int h, per, tot, off, w, s, e_busy, e_done, e_rd, e_wr, a, b, tw;
    h = (2 ** l) / 2;
    per = h + p;
    tot = l * per;
    e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0; s = 0;
    off = -1;
    if (c0 >= 0 && t > c0) off = t - c0 - 1;
    if (off >= 0 && off < tot) begin
      e_busy = 1;
      s = off / per;
      if (off % per < h) e_rd = 1;
    end
    if (off == tot) e_done = 1;
    w = off - p;
    if (off >= 0 && w >= 0 && w < tot && (w % per) < h) e_wr = 1;
    check({nm, " busy"}, o_busy, e_busy);
    check({nm, " done"}, o_done, e_done);
    check({nm, " rd_en"}, o_rd, e_rd);
    check({nm, " wr_en"}, o_wr, e_wr);
    if (!e_done) check({nm, " stage"}, o_stage, s);
    if (e_rd) begin
      addr_of(l, s, off % per, a, b, tw);
      check({nm, " rd_addr_a"}, o_ra, a);
      check({nm, " rd_addr_b"}, o_rb, b);
      check({nm, " tw_addr"}, o_tw, tw);
    end
    if (e_wr) begin
      addr_of(l, w / per, w % per, a, b, tw);
      check({nm, " wr_addr_a"}, o_wa, a);
      check({nm, " wr_addr_b"}, o_wb, b);
    end
  endtask

  // One cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input bit s0, input bit s1, input bit r);
    start0 = s0;
    start1 = s1;
    rst    = r;
    @(negedge clk);
    model_check("n8", 3, 5, c0_0, int'(busy0), int'(done0), int'(stage0), int'(rd_en0),
                int'(rd_a0), int'(rd_b0), int'(tw0), int'(wr_en0), int'(wr_a0), int'(wr_b0));
    model_check("n16", 4, 6, c0_1, int'(busy1), int'(done1), int'(stage1), int'(rd_en1),
                int'(rd_a1), int'(rd_b1), int'(tw1), int'(wr_en1), int'(wr_a1), int'(wr_b1));
    if (t <= 28 && wr_en0) wr_cnt0++;
    if (t == 28) check("n8 first run wr_en count", wr_cnt0, 12);
    if (r) begin
      c0_0 = -1;
      c0_1 = -1;
    end else begin
      if (s0 && is_idle(3, 5, c0_0, t)) c0_0 = t;
      if (s1 && is_idle(4, 6, c0_1, t)) c0_1 = t;
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  int st0_q[$] = '{0, 5, 28, 29, 60, 69};
  int st1_q[$] = '{0, 57, 58, 80};

  initial begin
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset n8 outputs", int'({busy0, done0, stage0, rd_en0, rd_a0, rd_b0, tw0,
                                     wr_en0, wr_a0, wr_b0}), 0);
    check("reset n16 outputs", int'({busy1, done1, stage1, rd_en1, rd_a1, rd_b1, tw1,
                                      wr_en1, wr_a1, wr_b1}), 0);
    @(posedge clk);
    #1;
    t = 0;
    // Directed: ignored starts in RUN and FIN, back-to-back restart,
    // a mid-run reset and a clean run afterwards.
    for (int i = 0; i < 140; i++) begin
      step((t inside {st0_q}), (t inside {st1_q}), (t == 66));
    end
    // Random start pulses with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 12) == 0),
           ($urandom_range(0, 299) == 0));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_stage_ctrl.md
Name: fft_stage_ctrl

Overview:
Sequencer for an in-place radix-2 DIT FFT built around the pipelined butterfly unit and a dual-port working memory.
- On start, it walks LOG2N stages, issuing one butterfly per cycle: read addresses A/B and twiddle ROM address.
- It generates the matching delayed write-back addresses and drains the pipeline between stages to avoid read-after-write hazards.
- It signals done when the last result is written. Input bit-reversal is handled by the loader, not here.

Parameters:
- LOG2N, 3, log2 of FFT length N (N = 2^LOG2N, 2..10 supported).
- RD_LAT, 1, memory read latency in cycles (rd_en to data at butterfly inputs).
- BF_LAT, 4, butterfly latency in cycles (inputs to out_a/out_b valid).
- STAGE_W, 4, width of stage index output.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle request to run one FFT; honoured only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after final write-back.
- stage  out  STAGE_W  current stage index s (0..LOG2N-1).
- rd_en  out  1  read/issue strobe to memory and butterfly.
- rd_addr_a  out  LOG2N  memory address of butterfly input a.
- rd_addr_b  out  LOG2N  memory address of butterfly input b.
- tw_addr  out  LOG2N-1  twiddle ROM address, aligned with rd_en.
- wr_en  out  1  write strobe for out_a/out_b.
- wr_addr_a  out  LOG2N  write address for out_a.
- wr_addr_b  out  LOG2N  write address for out_b.

Behaviour:
- Reset: state IDLE; all outputs 0; stage/k counters 0; write delay line cleared (no stray wr_en after reset).
- Reset mid-run aborts immediately; no done pulse.
- The FSM has four states: IDLE, RUN, DRAIN, FIN.
  - IDLE: on start -> RUN with s=0, k=0. start in any other state is ignored.
  - RUN: rd_en=1 each cycle, k increments 0..N/2-1. After k=N/2-1 -> DRAIN with drain counter 0.
  - DRAIN: rd_en=0 for PIPE_LAT = RD_LAT+BF_LAT cycles. At the last drain cycle: if s<LOG2N-1, then s++, k=0, -> RUN; else -> FIN.
  - FIN: done=1 and busy=0 for one cycle -> IDLE.
- Address generation, registered and aligned with rd_en:
  - span = 2^s; pos = k mod span; group = k / span.
  - rd_addr_a = group*2*span + pos; rd_addr_b = rd_addr_a + span.
  - tw_addr = pos << (LOG2N-1-s).
- Write-back: a PIPE_LAT-deep delay line carries {valid, addr_a, addr_b}. wr_en/wr_addr_* equal rd_en/rd_addr_* delayed exactly PIPE_LAT cycles.
- The last write of a stage lands on the last DRAIN cycle. The next stage's first read occurs the following cycle, so memory must be write-before-read across a cycle boundary.
- Timing: start sampled at cycle 0 -> first rd_en at cycle 1.
  - Each stage takes N/2 + PIPE_LAT cycles.
  - done at cycle LOG2N*(N/2+PIPE_LAT)+1. For the defaults this is cycle 28.
- busy=1 in RUN and DRAIN; 0 in IDLE and FIN.
- stage holds s throughout RUN/DRAIN; it is 0 in IDLE.
- Back-to-back: start asserted in the FIN cycle is ignored. start in the next cycle (IDLE) is accepted.
- No arithmetic on data. Scaling (>>>1 per stage) belongs to the butterfly.

Test Plan:
1. N=8 defaults, start at cycle 0 -> rd_en cycles 1-4, stage-0 pairs (0,1),(2,3),(4,5),(6,7), tw_addr 0,0,0,0; wr_en cycles 6-9 with the same pairs.
2. Continue run -> stage 1 reads start at cycle 10: pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2. Stage 2 reads start at cycle 19: pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3.
3. Same run -> done high only at cycle 28; busy high cycles 1-27; exactly 12 wr_en pulses in total.
4. start pulsed at cycles 5 and 28 during a run -> both ignored; start at 29 -> new run with first rd_en at 30.
5. rst asserted at cycle 7 -> outputs 0 from cycle 8, no wr_en or done thereafter; a start at cycle 10 runs normally (done at 38).
6. LOG2N=4, RD_LAT=2 -> 8 reads per stage, PIPE_LAT=6; stage-3 tw_addr sequence 0..7; done at cycle 57.
